// File: rtl/fetch_pc_queue.sv
// fetch_pc_queue: generates FETCH_WIDTH-wide sequential PC groups into a FIFO,
// with a flush on a jal/jalr redirect and optional fetch-block alignment.
module fetch_pc_queue #(
  parameter int              XLEN        = 32,
  parameter int              FETCH_WIDTH = 2,
  parameter int              QUEUE_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter bit              ALIGN_GROUP = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        jal,
  input  logic [XLEN-1:0]             jal_addr,
  input  logic                        jalr_jcond,
  input  logic [XLEN-1:0]             jalr_jcond_addr,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [FETCH_WIDTH*XLEN-1:0] fetch_instr_pc,
  output logic [FETCH_WIDTH-1:0]      out_lane_valid,
  output logic                        busy
);
  localparam int GW = FETCH_WIDTH * XLEN;
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int OW = $clog2(4 * FETCH_WIDTH);
  localparam logic [PW:0] FULL = (PW + 1)'(QUEUE_DEPTH);
  localparam logic [XLEN-1:0] GMASK = ALIGN_GROUP ? ~XLEN'((1 << OW) - 1) : '1;
  localparam logic [OW-1:0] RST_OFF = ALIGN_GROUP ? RESET_PC[OW-1:0] : '0;

  logic [XLEN-1:0]        pc_q, pc_d, tgt;
  logic [OW-1:0]          off_q, off_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]            count_q, count_d;
  logic [GW-1:0]          grp_q [QUEUE_DEPTH];
  logic [GW-1:0]          grp_d [QUEUE_DEPTH];
  logic [FETCH_WIDTH-1:0] lv_q [QUEUE_DEPTH];
  logic [FETCH_WIDTH-1:0] lv_d [QUEUE_DEPTH];
  logic [GW-1:0]          grp;
  logic [FETCH_WIDTH-1:0] lv;
  logic                   redirect, deq, enq;

  // pc_q is already group-aligned when ALIGN_GROUP=1; off_q masks the lanes
  // below the true entry PC of the first group after a redirect or reset.
  always_comb begin
    redirect = jal | jalr_jcond;
    tgt      = (jalr_jcond ? jalr_jcond_addr : jal_addr) & ~XLEN'(3);
    deq      = (count_q != '0) & out_ready & ~redirect;
    enq      = ~redirect & ((count_q != FULL) | deq);
    grp      = '0;
    lv       = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      grp[i*XLEN +: XLEN] = pc_q + XLEN'(4 * i);
      lv[i]               = ~ALIGN_GROUP | (OW'(4 * i) >= off_q);
    end
    grp_d    = grp_q;
    lv_d     = lv_q;
    if (enq) begin
      grp_d[wr_ptr_q] = grp;
      lv_d[wr_ptr_q]  = lv;
    end
    wr_ptr_d = wr_ptr_q + PW'(enq);
    rd_ptr_d = redirect ? wr_ptr_q : rd_ptr_q + PW'(deq);
    count_d  = redirect ? '0 : count_q + (PW + 1)'(enq) - (PW + 1)'(deq);
    pc_d     = redirect ? (tgt & GMASK) : enq ? pc_q + XLEN'(4 * FETCH_WIDTH) : pc_q;
    off_d    = redirect ? (ALIGN_GROUP ? tgt[OW-1:0] : '0) : enq ? '0 : off_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC & GMASK;
      off_q    <= RST_OFF;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      grp_q    <= '{default: '0};
      lv_q     <= '{default: '0};
    end else begin
      pc_q     <= pc_d;
      off_q    <= off_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      grp_q    <= grp_d;
      lv_q     <= lv_d;
    end
  end

  assign out_valid      = count_q != '0;
  assign busy           = count_q == FULL;
  assign fetch_instr_pc = out_valid ? grp_q[rd_ptr_q] : '0;
  assign out_lane_valid = out_valid ? lv_q[rd_ptr_q] : '0;
endmodule
